regfile_access_ctrl: RTL and testbench

// - Initiator/sequencer for the 2R1W register file: accepts op requests on a valid/ready port and drives the file's RD/WR/EN/address/data pins.
// - Captures Q1/Q2 after the file's one-edge read latency and returns them on a valid/ready response port.
// - Sits between the datapath/host and the register file instance.
// - Adds a sequenced CLEAR sweep, since the file's only bulk clear is Reset.

---
 rtl/regfile_access_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Request/response sequencer in front of a 2R1W register file, with a sequenced CLEAR sweep.
// Define RFC_BYPASS_EN to forward RDWR write data to matching read ports.
module regfile_access_ctrl #(
  parameter int M  = 32,
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  input  logic [AW-1:0] req_rd,
  input  logic [N-1:0]  req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N-1:0]  resp_q1,
  output logic [N-1:0]  resp_q2,
  output logic          resp_err,
  output logic          rf_EN,
  output logic          rf_RD,
  output logic          rf_WR,
  output logic [AW-1:0] rf_R1,
  output logic [AW-1:0] rf_R2,
  output logic [AW-1:0] rf_RW,
  output logic [N-1:0]  rf_Data_IN,
  input  logic [N-1:0]  rf_Q1,
  input  logic [N-1:0]  rf_Q2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_CLEAR,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RDWR  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [AW:0]   ADDR_LIMIT = (AW+1)'(M);
  localparam logic [AW-1:0] LAST_REG   = AW'(M - 1);

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] count_q, count_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [N-1:0]  resp_q1_q, resp_q1_d;
  logic [N-1:0]  resp_q2_q, resp_q2_d;
  logic          resp_err_q, resp_err_d;
  logic          rf_en_q, rf_en_d;
  logic          rf_rd_q, rf_rd_d;
  logic          rf_wr_q, rf_wr_d;
  logic [AW-1:0] rf_r1_q, rf_r1_d;
  logic [AW-1:0] rf_r2_q, rf_r2_d;
  logic [AW-1:0] rf_rw_q, rf_rw_d;
  logic [N-1:0]  rf_data_q, rf_data_d;

  logic rs1_bad, rs2_bad, rd_bad, req_err;

  // Only the addresses an op actually uses can make it fail.
  assign rs1_bad = ({1'b0, req_rs1} >= ADDR_LIMIT);
  assign rs2_bad = ({1'b0, req_rs2} >= ADDR_LIMIT);
  assign rd_bad  = ({1'b0, req_rd}  >= ADDR_LIMIT);

  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OP_READ:  req_err = rs1_bad | rs2_bad;
      OP_WRITE: req_err = rd_bad;
      OP_RDWR:  req_err = rs1_bad | rs2_bad | rd_bad;
      default:  req_err = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    count_d      = count_q;
    resp_valid_d = resp_valid_q;
    resp_q1_d    = resp_q1_q;
    resp_q2_d    = resp_q2_q;
    resp_err_d   = resp_err_q;
    rf_en_d      = 1'b0;
    rf_rd_d      = 1'b0;
    rf_wr_d      = 1'b0;
    rf_r1_d      = rf_r1_q;
    rf_r2_d      = rf_r2_q;
    rf_rw_d      = rf_rw_q;
    rf_data_d    = rf_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // The rf address/data registers double as the latched request.
          op_d       = req_op;
          rf_r1_d    = req_rs1;
          rf_r2_d    = req_rs2;
          rf_rw_d    = req_rd;
          rf_data_d  = req_wdata;
          resp_q1_d  = '0;
          resp_q2_d  = '0;
          resp_err_d = 1'b0;
          if (req_op == OP_CLEAR) begin
            state_d   = S_CLEAR;
            count_d   = '0;
            rf_en_d   = 1'b1;
            rf_wr_d   = 1'b1;
            rf_rw_d   = '0;
            rf_data_d = '0;
          end else if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            rf_en_d = 1'b1;
            rf_rd_d = (req_op != OP_WRITE);
            rf_wr_d = (req_op != OP_READ);
          end
        end
      end

      S_ISSUE: begin
        if (op_q == OP_WRITE) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        resp_q1_d = rf_Q1;
        resp_q2_d = rf_Q2;
`ifdef RFC_BYPASS_EN
        if (op_q == OP_RDWR) begin
          if (rf_r1_q == rf_rw_q) resp_q1_d = rf_data_q;
          if (rf_r2_q == rf_rw_q) resp_q2_d = rf_data_q;
        end
`endif
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end

      S_CLEAR: begin
        if (count_q == LAST_REG) begin
          count_d      = '0;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          count_d = count_q + AW'(1);
          rf_en_d = 1'b1;
          rf_wr_d = 1'b1;
          rf_rw_d = count_q + AW'(1);
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_q1_d    = '0;
          resp_q2_d    = '0;
          resp_err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_READ;
      count_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_q1_q    <= '0;
      resp_q2_q    <= '0;
      resp_err_q   <= 1'b0;
      rf_en_q      <= 1'b0;
      rf_rd_q      <= 1'b0;
      rf_wr_q      <= 1'b0;
      rf_r1_q      <= '0;
      rf_r2_q      <= '0;
      rf_rw_q      <= '0;
      rf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      count_q      <= count_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q1_q    <= resp_q1_d;
      resp_q2_q    <= resp_q2_d;
      resp_err_q   <= resp_err_d;
      rf_en_q      <= rf_en_d;
      rf_rd_q      <= rf_rd_d;
      rf_wr_q      <= rf_wr_d;
      rf_r1_q      <= rf_r1_d;
      rf_r2_q      <= rf_r2_d;
      rf_rw_q      <= rf_rw_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_q1    = resp_q1_q;
  assign resp_q2    = resp_q2_q;
  assign resp_err   = resp_err_q;
  assign rf_EN      = rf_en_q;
  assign rf_RD      = rf_rd_q;
  assign rf_WR      = rf_wr_q;
  assign rf_R1      = rf_r1_q;
  assign rf_R2      = rf_r2_q;
  assign rf_RW      = rf_rw_q;
  assign rf_Data_IN = rf_data_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: a behavioural 2R1W file behind the main instance,
// plus an M=24 instance for out-of-range address handling.
module tb_regfile_access_ctrl;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RDWR  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [1:0]  req_op;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic [31:0] req_wdata, resp_q1, resp_q2;
  logic        rf_EN, rf_RD, rf_WR;
  logic [4:0]  rf_R1, rf_R2, rf_RW;
  logic [31:0] rf_Data_IN, rf_Q1, rf_Q2;

  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
  logic [1:0]  b_req_op;
  logic [4:0]  b_req_rs1, b_req_rs2, b_req_rd;
  logic [31:0] b_req_wdata, b_resp_q1, b_resp_q2;
  logic        b_rf_EN, b_rf_RD, b_rf_WR;
  logic [4:0]  b_rf_R1, b_rf_R2, b_rf_RW;
  logic [31:0] b_rf_Data_IN;
  logic [31:0] b_rf_Q1 = 32'h0;
  logic [31:0] b_rf_Q2 = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_access_ctrl #(.M(32), .N(32), .AW(5)) dut (
    .Clock(clk), .Reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_q1(resp_q1), .resp_q2(resp_q2), .resp_err(resp_err),
    .rf_EN(rf_EN), .rf_RD(rf_RD), .rf_WR(rf_WR),
    .rf_R1(rf_R1), .rf_R2(rf_R2), .rf_RW(rf_RW), .rf_Data_IN(rf_Data_IN),
    .rf_Q1(rf_Q1), .rf_Q2(rf_Q2)
  );

  regfile_access_ctrl #(.M(24), .N(32), .AW(5)) dut24 (
    .Clock(clk), .Reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_rs1(b_req_rs1), .req_rs2(b_req_rs2), .req_rd(b_req_rd), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_q1(b_resp_q1), .resp_q2(b_resp_q2), .resp_err(b_resp_err),
    .rf_EN(b_rf_EN), .rf_RD(b_rf_RD), .rf_WR(b_rf_WR),
    .rf_R1(b_rf_R1), .rf_R2(b_rf_R2), .rf_RW(b_rf_RW), .rf_Data_IN(b_rf_Data_IN),
    .rf_Q1(b_rf_Q1), .rf_Q2(b_rf_Q2)
  );

  // Behavioural register file: read and write on the same edge, read sees the old value.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      rf_Q1 <= 32'h0;
      rf_Q2 <= 32'h0;
    end else begin
      if (rf_EN && rf_RD) begin
        rf_Q1 <= mem[rf_R1];
        rf_Q2 <= mem[rf_R2];
      end
      if (rf_EN && rf_WR) mem[rf_RW] <= rf_Data_IN;
    end
  end

  // Strobe monitor; the tasks toggle mon_en and read counters #1 after a negedge.
  logic mon_en = 1'b0;
  int en_cnt, wr_cnt, addr_bad;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rf_EN) en_cnt++;
      if (rf_WR) begin
        if (rf_RW !== 5'(wr_cnt) || rf_Data_IN !== 32'h0) addr_bad++;
        wr_cnt++;
      end
    end else begin
      en_cnt   = 0;
      wr_cnt   = 0;
      addr_bad = 0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic run_op(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] wdata, output int lat,
                        output logic [31:0] q1, output logic [31:0] q2, output logic err);
    @(negedge clk);
    req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wdata = wdata;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    q1 = resp_q1; q2 = resp_q2; err = resp_err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_op = OP_READ; req_rs1 = 0; req_rs2 = 0; req_rd = 0; req_wdata = 0;
    resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_op = OP_READ; b_req_rs1 = 0; b_req_rs2 = 0; b_req_rd = 0;
    b_req_wdata = 0; b_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    tests_run++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp: got valid=%b err=%b expected 0 0", resp_valid, resp_err); end
    tests_run++;
    if ({rf_EN, rf_RD, rf_WR} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_strobes: got %b expected 000", {rf_EN, rf_RD, rf_WR}); end
    tests_run++;
    if (resp_q1 !== 32'h0 || rf_RW !== 5'd0 || rf_Data_IN !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got q1=%h rw=%0d din=%h expected 0", resp_q1, rf_RW, rf_Data_IN); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] q1, q2; logic err;
    run_op(OP_WRITE, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, lat, q1, q2, err);
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("[TB] FAIL write_latency: got %0d expected 2", lat); end
    tests_run++;
    if (q1 !== 32'h0 || q2 !== 32'h0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_resp: got q1=%h q2=%h err=%b expected 0 0 0", q1, q2, err); end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_gap: got ready=%b valid=%b expected 1 0", req_ready, resp_valid); end
    run_op(OP_READ, 5'd5, 5'd0, 5'd0, 32'h0, lat, q1, q2, err);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
    tests_run++;
    if (q1 !== 32'hDEADBEEF || q2 !== 32'h0) begin tests_failed++; $display("[TB] FAIL read_data: got q1=%h q2=%h expected deadbeef 0", q1, q2); end
  endtask

  task automatic test_rdwr();
    int lat; logic [31:0] q1, q2, exp_q; logic err;
`ifdef RFC_BYPASS_EN
    exp_q = 32'h2222;
`else
    exp_q = 32'h1111;
`endif
    run_op(OP_WRITE, 5'd0, 5'd0, 5'd7, 32'h1111, lat, q1, q2, err);
    run_op(OP_RDWR, 5'd7, 5'd7, 5'd7, 32'h2222, lat, q1, q2, err);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("[TB] FAIL rdwr_latency: got %0d expected 3", lat); end
    tests_run++;
    if (q1 !== exp_q || q2 !== exp_q) begin tests_failed++; $display("[TB] FAIL rdwr_data: got q1=%h q2=%h expected %h", q1, q2, exp_q); end
    run_op(OP_READ, 5'd7, 5'd5, 5'd0, 32'h0, lat, q1, q2, err);
    tests_run++;
    if (q1 !== 32'h2222 || q2 !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL rdwr_readback: got q1=%h q2=%h expected 2222 deadbeef", q1, q2); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] q1, q2; logic err;
    @(negedge clk);
    req_op = OP_READ; req_rs1 = 5'd5; req_rs2 = 5'd7; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("[TB] FAIL bp_latency: got %0d expected 3", lat); end
    #1;
    req_op = OP_WRITE; req_rd = 5'd9; req_wdata = 32'h0000ABCD; req_valid = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b1 || resp_q1 !== 32'hDEADBEEF || resp_q2 !== 32'h2222 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold cycle %0d: got valid=%b q1=%h q2=%h ready=%b expected 1 deadbeef 2222 0", i, resp_valid, resp_q1, resp_q2, req_ready);
      end
    end
    #1;
    mon_en = 1'b0;
    tests_run++;
    if (en_cnt !== 0) begin tests_failed++; $display("[TB] FAIL bp_no_access: got %0d rf_EN cycles expected 0", en_cnt); end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0 1", resp_valid, req_ready); end
    run_op(OP_READ, 5'd9, 5'd9, 5'd0, 32'h0, lat, q1, q2, err);
    tests_run++;
    if (q1 !== 32'h0) begin tests_failed++; $display("[TB] FAIL bp_dropped_write: got r9=%h expected 0", q1); end
  endtask

  task automatic test_clear();
    int lat; logic [31:0] q1, q2; logic err;
    for (int i = 0; i < 32; i++)
      run_op(OP_WRITE, 5'd0, 5'd0, 5'(i), 32'h10000001 + 32'(i), lat, q1, q2, err);
    run_op(OP_READ, 5'd31, 5'd0, 5'd0, 32'h0, lat, q1, q2, err);
    tests_run++;
    if (q1 !== 32'h10000020 || q2 !== 32'h10000001) begin tests_failed++; $display("[TB] FAIL clear_preload: got q1=%h q2=%h expected 10000020 10000001", q1, q2); end
    #1;
    mon_en = 1'b1;
    run_op(OP_CLEAR, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, lat, q1, q2, err);
    #1;
    mon_en = 1'b0;
    tests_run++;
    if (lat !== 33) begin tests_failed++; $display("[TB] FAIL clear_latency: got %0d expected 33", lat); end
    tests_run++;
    if (wr_cnt !== 32) begin tests_failed++; $display("[TB] FAIL clear_wr_cycles: got %0d expected 32", wr_cnt); end
    tests_run++;
    if (addr_bad !== 0) begin tests_failed++; $display("[TB] FAIL clear_sequence: got %0d bad cycles expected 0", addr_bad); end
    tests_run++;
    if (q1 !== 32'h0 || q2 !== 32'h0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_resp: got q1=%h q2=%h err=%b expected 0", q1, q2, err); end
    for (int i = 0; i < 16; i++) begin
      run_op(OP_READ, 5'(2 * i), 5'(2 * i + 1), 5'd0, 32'h0, lat, q1, q2, err);
      tests_run++;
      if (q1 !== 32'h0 || q2 !== 32'h0) begin tests_failed++; $display("[TB] FAIL clear_readback r%0d/r%0d: got %h %h expected 0", 2 * i, 2 * i + 1, q1, q2); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int guard;
    @(negedge clk);
    req_op = OP_CLEAR; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!(rf_WR === 1'b1 && rf_RW === 5'd12) && guard < 100) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (guard !== 12) begin tests_failed++; $display("[TB] FAIL midclear_reach: got %0d cycles to count 12 expected 12", guard); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || rf_WR !== 1'b0 || rf_EN !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midclear_reset: got ready=%b wr=%b en=%b valid=%b expected 1 0 0 0", req_ready, rf_WR, rf_EN, resp_valid);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0 || rf_WR !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midclear_dropped: got valid=%b wr=%b ready=%b expected 0 0 1", resp_valid, rf_WR, req_ready); end
  endtask

  task automatic test_error();
    int lat; logic [31:0] q1, q2; logic err;
    @(negedge clk);
    b_req_op = OP_READ; b_req_rs1 = 5'd30; b_req_rs2 = 5'd0; b_req_valid = 1'b1; b_resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    tests_run++;
    if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_read_flag: got valid=%b err=%b expected 1 1", b_resp_valid, b_resp_err); end
    tests_run++;
    if (b_resp_q1 !== 32'h0 || b_resp_q2 !== 32'h0 || b_rf_EN !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_read_data: got q1=%h q2=%h en=%b expected 0 0 0", b_resp_q1, b_resp_q2, b_rf_EN); end
    b_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (b_resp_valid !== 1'b0 || b_resp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_release: got valid=%b err=%b expected 0 0", b_resp_valid, b_resp_err); end
    b_req_op = OP_WRITE; b_req_rd = 5'd23; b_req_wdata = 32'h55; b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    tests_run++;
    if (b_rf_EN !== 1'b1 || b_rf_WR !== 1'b1 || b_rf_RW !== 5'd23 || b_resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_inrange_issue: got en=%b wr=%b rw=%0d valid=%b expected 1 1 23 0", b_rf_EN, b_rf_WR, b_rf_RW, b_resp_valid); end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_inrange_resp: got valid=%b err=%b expected 1 0", b_resp_valid, b_resp_err); end
    @(posedge clk);
    @(negedge clk);
    b_req_op = OP_RDWR; b_req_rs1 = 5'd0; b_req_rs2 = 5'd1; b_req_rd = 5'd24; b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    tests_run++;
    if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b1 || b_rf_EN !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_rdwr_rd: got valid=%b err=%b en=%b expected 1 1 0", b_resp_valid, b_resp_err, b_rf_EN); end
    run_op(OP_READ, 5'd31, 5'd31, 5'd0, 32'h0, lat, q1, q2, err);
    tests_run++;
    if (err !== 1'b0 || lat !== 3) begin tests_failed++; $display("[TB] FAIL err_m32_top: got err=%b lat=%0d expected 0 3", err, lat); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rdwr();
    test_backpressure();
    test_clear();
    test_reset_mid_clear();
    test_error();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
